// File: rtl/register_access_arbiter_pkg.sv
// Shared constants and encodings for the two-requester register access arbiter.
package register_access_arbiter_pkg;

    localparam int DW = 2;
    localparam int CW = 2;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_WRRD    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    function automatic logic op_writes(input op_e op);
        return (op == OP_WRITE) || (op == OP_WRRD);
    endfunction

    function automatic logic op_reads(input op_e op);
        return (op == OP_READ) || (op == OP_WRRD);
    endfunction

endpackage

// File: rtl/register_access_arbiter_async_sync.sv
// Multi-flop synchronizer for one asynchronous level input, with a selectable reset value.
module async_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/register_access_arbiter.sv
// Round-robin arbiter that turns A/B register requests into control/data token
// handshakes on two transmitters, then optionally waits for a read token.
module register_access_arbiter
    import register_access_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 1023
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          a_req,
    input  logic [1:0]    a_op,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic [1:0]    b_op,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [CW-1:0] cx_val,
    output logic          cx_go,
    input  logic          cxe,
    output logic [DW-1:0] tx_val,
    output logic          tx_go,
    input  logic          txe,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          busy,
    output logic          grant,
    output logic [7:0]    tok_count,
    output logic          timeout_err,
    output logic          op_err
);

    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d, sel_op;
    logic          grant_q, grant_d;
    logic          prio_b_q, prio_b_d;
    logic [CW-1:0] cx_val_q, cx_val_d;
    logic [DW-1:0] tx_val_q, tx_val_d, sel_wdata;
    logic          cx_go_q, cx_go_d, tx_go_q, tx_go_d;
    logic [7:0]    tok_q, tok_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q, tmo_err_d, op_err_q, op_err_d;
    logic          rxv_prev_q;
    logic          cxe_s, txe_s, rxv_s;
    logic          pick_b, wr, en_hi, en_lo, rx_rise;

    // Enables idle high, so their synchronizers come out of reset at 1.
    async_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cxe (
        .clk(CLK), .rst_n_i(RESET), .d_i(cxe), .q_o(cxe_s));
    async_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_txe (
        .clk(CLK), .rst_n_i(RESET), .d_i(txe), .q_o(txe_s));
    async_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rxv (
        .clk(CLK), .rst_n_i(RESET), .d_i(rx_valid), .q_o(rxv_s));

    assign wr      = op_writes(op_q);
    assign en_hi   = cxe_s && (!wr || txe_s);
    assign en_lo   = !cxe_s && (!wr || !txe_s);
    assign rx_rise = rxv_s && !rxv_prev_q;
    assign pick_b    = b_req && (!a_req || prio_b_q);
    assign sel_op    = pick_b ? op_e'(b_op) : op_e'(a_op);
    assign sel_wdata = pick_b ? b_wdata : a_wdata;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        grant_d   = grant_q;
        prio_b_d  = prio_b_q;
        cx_val_d  = cx_val_q;
        tx_val_d  = tx_val_q;
        cx_go_d   = cx_go_q;
        tx_go_d   = tx_go_q;
        tok_d     = tok_q;
        rdata_d   = rdata_q;
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
        op_err_d  = op_err_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    grant_d  = pick_b;
                    prio_b_d = !pick_b;
                    op_d     = sel_op;
                    cx_val_d = sel_op;
                    tx_val_d = sel_wdata;
                    rdata_d  = '0;
                    if (sel_op == OP_ILLEGAL) begin
                        op_err_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (en_hi) begin
                    cx_go_d = 1'b1;
                    tx_go_d = wr;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (en_lo) begin
                    cx_go_d = 1'b0;
                    tx_go_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (en_hi) begin
                    tok_d = tok_q + 8'd1;
                    tmo_d = '0;
                    state_d = op_reads(op_q) ? ST_RD_WAIT : ST_RESP;
                end
            end
            ST_RD_WAIT: begin
                if (rx_rise) begin
                    rdata_d = rx_data;
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            grant_q    <= 1'b0;
            prio_b_q   <= 1'b0;
            cx_val_q   <= '0;
            tx_val_q   <= '0;
            cx_go_q    <= 1'b0;
            tx_go_q    <= 1'b0;
            tok_q      <= '0;
            rdata_q    <= '0;
            tmo_q      <= '0;
            tmo_err_q  <= 1'b0;
            op_err_q   <= 1'b0;
            rxv_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            grant_q    <= grant_d;
            prio_b_q   <= prio_b_d;
            cx_val_q   <= cx_val_d;
            tx_val_q   <= tx_val_d;
            cx_go_q    <= cx_go_d;
            tx_go_q    <= tx_go_d;
            tok_q      <= tok_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            tmo_err_q  <= tmo_err_d;
            op_err_q   <= op_err_d;
            rxv_prev_q <= rxv_s;
        end
    end

    assign a_ack       = (state_q == ST_RESP) && !grant_q;
    assign b_ack       = (state_q == ST_RESP) && grant_q;
    assign a_rdata     = a_ack ? rdata_q : '0;
    assign b_rdata     = b_ack ? rdata_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign grant       = grant_q;
    assign cx_val      = cx_val_q;
    assign tx_val      = tx_val_q;
    assign cx_go       = cx_go_q;
    assign tx_go       = tx_go_q;
    assign tok_count   = tok_q;
    assign timeout_err = tmo_err_q;
    assign op_err      = op_err_q;

endmodule

// File: doc/register_access_arbiter.md
REGISTER_ACCESS_ARBITER -- requirements
Module: register_access_arbiter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on every asynchronous input.
REQ-002 SHALL have parameter RD_TIMEOUT, default 1023, max cycles waiting for read data.
REQ-003 SHALL have port CLK  in  1  sole clock.
REQ-004 SHALL have port RESET  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports a_req/b_req  in  1  requester A/B request, held until ack.
REQ-006 SHALL have ports a_op/b_op  in  2  op: 00 read, 01 write, 10 write+read, 11 illegal.
REQ-007 SHALL have ports a_wdata/b_wdata  in  2  write data.
REQ-008 SHALL have ports a_ack/b_ack  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports a_rdata/b_rdata  out  2  read data, valid in ack cycle.
REQ-010 SHALL have ports cx_val  out  2, cx_go  out  1, cxe  in  1 (async): control-token transmitter channel.
REQ-011 SHALL have ports tx_val  out  2, tx_go  out  1, txe  in  1 (async): data-token transmitter channel.
REQ-012 SHALL have ports rx_valid  in  1 (async), rx_data  in  2: read-token receiver output.
REQ-013 SHALL have ports busy  out  1, grant  out  1 (0=A, 1=B), tok_count  out  8, timeout_err  out  1, op_err  out  1.

Function
REQ-014 SHALL implement states IDLE, ISSUE, HOLD, RELEASE, RD_WAIT, RESP.
REQ-015 IDLE: SHALL grant round-robin, favouring the requester not last granted; A wins the first tie after reset; latch op/wdata into cx_val/tx_val; next cycle ISSUE.
REQ-016 Illegal op (11): SHALL skip token issue, go to RESP with rdata 00, set op_err sticky.
REQ-017 ISSUE: SHALL raise cx_go (and tx_go if op is 01/10) the cycle after synced cxe (and synced txe if writing) is high; then HOLD.
REQ-018 HOLD: SHALL keep go high until synced cxe low (and synced txe low if writing), then drop both go signals; RELEASE.
REQ-019 RELEASE: SHALL wait for synced cxe high (and txe if writing); increment tok_count (wrap 255->0); go to RD_WAIT if op 00/10, else RESP.
REQ-020 cx_val/tx_val SHALL remain stable from grant until RELEASE exits; tx_go SHALL never rise for op 00.
REQ-021 RD_WAIT: SHALL capture rx_data on synced rising edge of rx_valid, then RESP.
REQ-022 RD_WAIT: SHALL after RD_TIMEOUT cycles without rx_valid set timeout_err sticky, return rdata 00, go to RESP.
REQ-023 RESP: SHALL pulse ack of granted requester for exactly one cycle with rdata (00 for write-only), then IDLE.
REQ-024 busy SHALL be high in every state except IDLE; grant SHALL be stable while busy.
REQ-025 Requests arriving while busy SHALL wait; a req dropped before ack is a protocol violation and is ignored until IDLE.

Reset
REQ-026 While RESET is low at a CLK edge, SHALL enter IDLE; all outputs 0; tok_count 0; sticky errors cleared; round-robin pointer to A.
REQ-027 Reset mid-token SHALL drop cx_go/tx_go in the same cycle; no ack SHALL be issued for the aborted op.
REQ-028 Synchronizer flops SHALL be reset to 1 for cxe/txe and 0 for rx_valid.

Structure
REQ-029 Op encodings, state encoding and DW=2/CW=2 constants SHALL live in a shared package.
REQ-030 The SYNC_STAGES flop chain SHALL be a sub-module, async_sync, instantiated per async input.

Verification
REQ-031 A write op 01, wdata 11, enables echo after 3 cycles -> cx_val 01, tx_val 11, both go pulses, a_ack once, tok_count 1.
REQ-032 B read op 00, rx_valid with rx_data 10 -> tx_go stays low, b_rdata 10 in b_ack cycle.
REQ-033 A and B request same cycle, both op 10, repeated twice -> grant order A,B,A,B; tok_count 4.
REQ-034 A read, rx_valid never asserted -> ack after RD_TIMEOUT+ cycles, rdata 00, timeout_err high until reset.
REQ-035 RESET low during HOLD -> go low next edge, no ack, tok_count 0; op 11 afterward -> ack, no go, op_err set.
